// File: rtl/wseq_pkg.sv
// rtl/wseq_pkg.sv - shared state type, widths and clog2 helper for the weight sequencer
package wseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } wseq_state_e;

    // 16-bit signed weight times 9-bit zero-extended pixel
    localparam int PROD_W    = 25;
    localparam int ACC_W_DEF = 32;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/wseq_mac.sv
// rtl/wseq_mac.sv - signed weight x unsigned pixel multiply-accumulate with bias-tap select
module wseq_mac
    import wseq_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int BIAS_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_vld,
    input  logic             i_bias,
    input  logic [15:0]      i_weight,
    input  logic [7:0]       i_pixel,
    output logic [ACC_W-1:0] o_acc
);

    logic signed [PROD_W-1:0] w_wt25;
    logic signed [PROD_W-1:0] w_px25;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_wext;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_wt25 = {{(PROD_W-16){i_weight[15]}}, i_weight};
    assign w_px25 = {{(PROD_W-8){1'b0}}, i_pixel};
    assign w_prod = w_wt25 * w_px25;
    assign w_wext = {{(ACC_W-16){i_weight[15]}}, i_weight};

    // The bias word ignores the pixel lane and is scaled up instead
    assign w_term = i_bias ? (w_wext <<< BIAS_SHIFT)
                           : {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_vld) begin
            r_acc <= r_acc + w_term;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/weight_seq_ctrl.sv
// rtl/weight_seq_ctrl.sv - weight ROM / pixel buffer dot-product sequencer
// Define WSEQ_BIAS_EN to read one extra bias word at address N_TAPS.
module weight_seq_ctrl
    import wseq_pkg::*;
#(
    parameter int N_TAPS     = 144,
    parameter int RD_LAT     = 1,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int BIAS_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             rom_ce,
    output logic             rom_oce,
    output logic             rom_reset,
    output logic [7:0]       rom_ad,
    input  logic [15:0]      rom_dout,
    output logic [7:0]       px_addr,
    input  logic [7:0]       px_data,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready
);

`ifdef WSEQ_BIAS_EN
    localparam int N_WORDS = N_TAPS + 1;
`else
    localparam int N_WORDS = N_TAPS;
`endif
    localparam logic [7:0] LAST = 8'(N_WORDS - 1);

    if (N_TAPS < 1 || N_TAPS > 255) begin : g_bad_taps
        $error("weight_seq_ctrl: N_TAPS out of range 1..255");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("weight_seq_ctrl: RD_LAT must be 1 or 2");
    end
    if (ACC_W < PROD_W + clog2(N_WORDS + 1)) begin : g_bad_accw
        $error("weight_seq_ctrl: ACC_W too narrow for worst-case sum");
    end

    wseq_state_e       r_state;
    logic [7:0]        r_cnt;
    logic [RD_LAT-1:0] r_vpipe;
    logic [RD_LAT-1:0] r_bpipe;
    logic              r_out_valid;
    logic              w_issue;
    logic              w_clr;
    logic              w_bias_now;
    logic [RD_LAT-1:0] w_vlow;
    logic              w_drain_done;

    assign w_issue = (r_state == ST_ISSUE);
    assign w_clr   = (r_state == ST_IDLE) && start;

`ifdef WSEQ_BIAS_EN
    assign w_bias_now = w_issue && (r_cnt == LAST);
`else
    assign w_bias_now = 1'b0;
`endif

    // Drain ends when only the pipe's output stage can still hold a tap
    assign w_vlow       = r_vpipe << 1;
    assign w_drain_done = (w_vlow == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_vpipe     <= '0;
            r_bpipe     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_vpipe[0] <= w_issue;
            r_bpipe[0] <= w_bias_now;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_bpipe[i] <= r_bpipe[i-1];
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ISSUE;
                        r_cnt   <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt == LAST) r_state <= ST_DRAIN;
                    else               r_cnt   <= r_cnt + 8'd1;
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    wseq_mac #(
        .ACC_W      (ACC_W),
        .BIAS_SHIFT (BIAS_SHIFT)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_vld    (r_vpipe[RD_LAT-1]),
        .i_bias   (r_bpipe[RD_LAT-1]),
        .i_weight (rom_dout),
        .i_pixel  (px_data),
        .o_acc    (acc_out)
    );

    assign busy      = (r_state != ST_IDLE);
    assign rom_ce    = w_issue;
    assign rom_oce   = (RD_LAT == 2) ? 1'b1 : 1'b0;
    assign rom_reset = ~rst_n;
    assign rom_ad    = r_cnt;
    assign px_addr   = r_cnt;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// tb/tb_weight_seq_ctrl.sv - scoreboard bench for weight_seq_ctrl in three configurations
`timescale 1ns/1ps
module tb_weight_seq_ctrl;

`ifdef WSEQ_BIAS_EN
    localparam int BX = 1;
`else
    localparam int BX = 0;
`endif

    typedef struct {
        int          inst;
        logic [31:0] acc;
        int          vcyc;
    } exp_t;

    logic            clk = 1'b0;
    logic [2:0]      rst_n = '0;
    logic [2:0]      start = '0;
    logic [2:0]      out_ready = '0;
    wire  [2:0]      busy, rom_ce, rom_oce, rom_reset, out_valid;
    wire  [2:0][7:0] rom_ad, px_addr, px_data;
    wire  [2:0][15:0] rom_dout;
    wire  [2:0][31:0] acc_out;

    logic [15:0] wmem [3][256];
    logic [7:0]  pmem [3][256];
    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          rise [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance 0: 144 taps bypass, 1: 144 taps pipelined, 2: single tap
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int NT = (g == 2) ? 1 : 144;
        localparam int RL = (g == 1) ? 2 : 1;
        logic [15:0] r_dq1, r_dq2;
        logic [7:0]  r_pq1, r_pq2;

        weight_seq_ctrl #(
            .N_TAPS(NT), .RD_LAT(RL), .ACC_W(32), .BIAS_SHIFT(8)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .start     (start[g]),
            .busy      (busy[g]),
            .rom_ce    (rom_ce[g]),
            .rom_oce   (rom_oce[g]),
            .rom_reset (rom_reset[g]),
            .rom_ad    (rom_ad[g]),
            .rom_dout  (rom_dout[g]),
            .px_addr   (px_addr[g]),
            .px_data   (px_data[g]),
            .acc_out   (acc_out[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g])
        );

        always @(posedge clk) begin
            if (rom_ce[g])  r_dq1 <= wmem[g][rom_ad[g]];
            if (rom_oce[g]) r_dq2 <= r_dq1;
            r_pq1 <= pmem[g][px_addr[g]];
            r_pq2 <= r_pq1;
        end
        assign rom_dout[g] = (RL == 2) ? r_dq2 : r_dq1;
        assign px_data[g]  = (RL == 2) ? r_pq2 : r_pq1;
    end

    function automatic int nt(input int g);
        return (g == 2) ? 1 : 144;
    endfunction

    function automatic int rl(input int g);
        return (g == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fill(input int g, input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       begin wmem[g][i] = 16'h0001; pmem[g][i] = 8'hFF; end
                1:       begin wmem[g][i] = 16'h8000; pmem[g][i] = 8'hFF; end
                2:       begin wmem[g][i] = 16'(i * 311 - 20000); pmem[g][i] = 8'(i * 7 + 3); end
                3:       begin wmem[g][i] = 16'h0000; pmem[g][i] = 8'h5A; end
                default: begin wmem[g][i] = 16'hFFFF; pmem[g][i] = 8'h02; end
            endcase
        end
        wmem[g][nt(g)] = 16'h0003;
    endtask

    function automatic logic [31:0] exp_sum(input int g);
        longint s = 0;
        for (int i = 0; i < nt(g); i++)
            s += longint'($signed(wmem[g][i])) * longint'(pmem[g][i]);
        if (BX == 1) s += longint'($signed(wmem[g][nt(g)])) * 256;
        return s[31:0];
    endfunction

    // Uniform patterns use hand-computed sums; bias word is 3 << 8 = 768
    function automatic logic [31:0] exp_val(input int g, input int mode);
        case (mode)
            0:       return 32'(36720 + BX * 768);
            1:       return 32'(-1203240960 + BX * 768);
            3:       return 32'(BX * 768);
            4:       return 32'(-2 + BX * 768);
            default: return exp_sum(g);
        endcase
    endfunction

    task automatic do_op(input int g, input int mode, input int hold);
        exp_t e;
        int   s, n, ce_cnt, max_ad, bad;
        @(negedge clk);
        start[g] = 1'b1;
        s = cyc;
        e.inst = g;
        e.acc  = exp_val(g, mode);
        e.vcyc = s + nt(g) + rl(g) + 1 + BX;
        sb.push_back(e);
        @(negedge clk);
        start[g] = 1'b0;
        n = 0; ce_cnt = 0; max_ad = 0; bad = 0;
        while (out_valid[g] !== 1'b1 && n < 1000) begin
            if (rom_ce[g]) begin
                ce_cnt++;
                if (int'(rom_ad[g]) > max_ad) max_ad = int'(rom_ad[g]);
                if (px_addr[g] != rom_ad[g]) bad++;
            end
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", longint'(n < 1000), 1);
        chk("rom_ce_cycles", ce_cnt, nt(g) + BX);
        chk("rom_ad_last", max_ad, nt(g) - 1 + BX);
        chk("px_addr_match", bad, 0);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            start[g] = (i % 4 == 0);
            @(negedge clk);
            if (out_valid[g] !== 1'b1 || acc_out[g] !== e.acc) bad++;
        end
        start[g] = 1'b0;
        if (hold > 0) chk("hold_stable", bad, 0);
        out_ready[g] = 1'b1;
        @(negedge clk);
        out_ready[g] = 1'b0;
        chk("idle_after_hs", {busy[g], out_valid[g]}, 0);
        repeat (3) @(negedge clk);
        chk("no_queued_start", busy[g], 0);
    endtask

    initial begin : monitor
        logic [2:0] pv;
        exp_t       e;
        pv = '0;
        forever begin
            @(negedge clk);
            #1;
            for (int m = 0; m < 3; m++) begin
                if (out_valid[m] && !pv[m]) rise[m] = cyc;
                pv[m] = out_valid[m];
                if (out_valid[m] && out_ready[m]) begin
                    chk("sb_nonempty", longint'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("sb_inst", m, e.inst);
                        chk("acc_out", $signed(acc_out[m]), $signed(e.acc));
                        chk("valid_latency", rise[m], e.vcyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        for (int g = 0; g < 3; g++) fill(g, 0);
        rst_n = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, rom_ce, out_valid, rom_ad[0], rom_ad[1], rom_ad[2]}, 0);
        for (int g = 0; g < 3; g++) chk("rst_acc", acc_out[g], 0);
        chk("rst_rom_reset", rom_reset, 3'b111);
        chk("rom_oce", rom_oce, 3'b010);
        rst_n = '1;
        @(negedge clk);
        chk("rom_reset_rel", rom_reset, 0);

        fill(0, 0); do_op(0, 0, 0);
        fill(0, 1); do_op(0, 1, 0);
        fill(1, 1); do_op(1, 1, 20);
        fill(0, 2); do_op(0, 2, 0);

        // abort mid-sum at tap 50, then a clean run must carry no residue
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (!(rom_ce[0] && rom_ad[0] == 8'd50) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_tap50", longint'(n < 500), 1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {busy[0], rom_ce[0], rom_ad[0], px_addr[0], acc_out[0], out_valid[0]}, 0);
        chk("abort_rom_reset", rom_reset[0], 1);
        rst_n[0] = 1'b1;
        do_op(0, 2, 0);

        fill(1, 2); do_op(1, 2, 0);
        fill(2, 4); do_op(2, 4, 0);
        fill(0, 3); do_op(0, 3, 0);
        fill(2, 2); do_op(2, 2, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
